reg_select_unit: RTL and testbench

- Parametrised successor to the combinational register-select/encode logic of the Mini SRC datapath.
- Holds its own IR copy and decodes the Ra/Rb/Rc fields with fixed priority into one-hot register in/out enables.
- Produces sign- or zero-extended constant C, suppresses R0 on base-address reads, and keeps a pending-write scoreboard that flags read-after-write hazards for the control unit.
- Sits between the IR load path and the register file; drives register enables directly.

---
 rtl/reg_select_unit_pkg.sv | 43 ++++
 rtl/reg_select_unit_onehot_decoder.sv | 18 +
 rtl/reg_select_unit.sv | 116 +++++++++++
 tb/tb_reg_select_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_select_unit_pkg.sv
// Shared definitions for the register-select unit: IR field placement,
// index-width derivation and the gra > grb > grc select priority.
package reg_select_unit_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int CONST_W_DEF  = 19;
  localparam int RA_LSB_DEF   = 23;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RA   = 2'd1,
    SEL_RB   = 2'd2,
    SEL_RC   = 2'd3
  } sel_field_e;

  // Bits needed to index n registers; never less than one.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Rb and Rc sit directly below Ra, each one index-width lower.
  function automatic int field_lsb(input int ra_lsb, input int idx_w, input sel_field_e f);
    case (f)
      SEL_RB:  return ra_lsb - idx_w;
      SEL_RC:  return ra_lsb - 2 * idx_w;
      default: return ra_lsb;
    endcase
  endfunction

  function automatic sel_field_e prio_sel(input logic gra, input logic grb, input logic grc);
    if (gra)      return SEL_RA;
    else if (grb) return SEL_RB;
    else if (grc) return SEL_RC;
    else          return SEL_NONE;
  endfunction

endpackage

// File: rtl/reg_select_unit_onehot_decoder.sv
// Index to one-hot decoder with enable; indices beyond NUM_REGS decode to zero.
module onehot_decoder #(
  parameter int IDX_W    = 4,
  parameter int NUM_REGS = 16
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_select_unit.sv
// Register-select unit: latches the IR, decodes Ra/Rb/Rc into register enables,
// extends constant C and tracks pending writes to flag read-after-write hazards.
module reg_select_unit
  import reg_select_unit_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CONST_W  = CONST_W_DEF,
  parameter int RA_LSB   = RA_LSB_DEF,
  localparam int IDX_W   = idx_width(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                ir_load,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  input  logic                c_zext,
  input  logic                reserve,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  output logic [DATA_W-1:0]   ir_q,
  output logic [NUM_REGS-1:0] r_en,
  output logic [NUM_REGS-1:0] r_out,
  output logic [DATA_W-1:0]   c_ext,
  output logic [IDX_W-1:0]    sel_idx,
  output logic                ba_zero,
  output logic                hazard,
  output logic                sel_err,
  output logic [NUM_REGS-1:0] busy
);

  localparam int RB_LSB = field_lsb(RA_LSB, IDX_W, SEL_RB);
  localparam int RC_LSB = field_lsb(RA_LSB, IDX_W, SEL_RC);
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   ir_reg_q, ir_reg_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  sel_field_e         sel_field;
  logic               any_sel;
  logic               in_range;
  logic               rd_active;
  logic               en_in, en_out;
  logic [CONST_W-1:0] c_field;

  always_comb begin
    ir_reg_d = ir_load ? ir_in : ir_reg_q;
  end

  always_comb begin
    sel_field = prio_sel(gra, grb, grc);
    any_sel   = gra | grb | grc;
    sel_err   = (gra & grb) | (gra & grc) | (grb & grc);
    case (sel_field)
      SEL_RA:  sel_idx = ir_reg_q[RA_LSB +: IDX_W];
      SEL_RB:  sel_idx = ir_reg_q[RB_LSB +: IDX_W];
      SEL_RC:  sel_idx = ir_reg_q[RC_LSB +: IDX_W];
      default: sel_idx = '0;
    endcase
    // Only reachable when NUM_REGS is not a power of two.
    in_range  = ({1'b0, sel_idx} < NUM_REGS_W);
    rd_active = (rout | baout) & any_sel & in_range;
    // R0 under baout reads as literal zero, so it is neither driven nor a hazard.
    ba_zero   = baout & any_sel & (sel_idx == '0);
    en_in     = rin & any_sel & in_range;
    en_out    = rd_active & ~ba_zero;
    hazard    = en_out & busy_q[sel_idx];
  end

  always_comb begin
    c_field = ir_reg_q[CONST_W-1:0];
    if (c_zext) c_ext = {{(DATA_W - CONST_W){1'b0}}, c_field};
    else        c_ext = {{(DATA_W - CONST_W){c_field[CONST_W-1]}}, c_field};
  end

  // wb_valid is a valid-only strobe with no ready: a write-back is consumed the
  // cycle it is presented, and a reserve of the same register that cycle wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_valid && (wb_idx == IDX_W'(i))) busy_d[i] = 1'b0;
      if (reserve && any_sel && in_range && (sel_idx == IDX_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg_q <= '0;
      busy_q   <= '0;
    end else begin
      ir_reg_q <= ir_reg_d;
      busy_q   <= busy_d;
    end
  end

  onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_dec_in (
    .idx    (sel_idx),
    .en     (en_in),
    .onehot (r_en)
  );

  onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_dec_out (
    .idx    (sel_idx),
    .en     (en_out),
    .onehot (r_out)
  );

  assign ir_q = ir_reg_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_reg_select_unit.sv
// Self-checking bench for reg_select_unit: directed scenarios plus a randomized
// run compared against a field-arithmetic reference model.
module tb_reg_select_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] ir_in;
  logic        ir_load, gra, grb, grc, rin, rout, baout, c_zext, reserve, wb_valid;
  logic [3:0]  wb_idx;
  logic [31:0] ir_q;
  logic [15:0] r_en, r_out, busy;
  logic [31:0] c_ext;
  logic [3:0]  sel_idx;
  logic        ba_zero, hazard, sel_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ir_m;
  logic [15:0] busy_m, busy_n;
  logic [31:0] ir_n;
  logic [15:0] e_r_en, e_r_out;
  logic [31:0] e_c_ext;
  int          e_sel_idx;
  logic        e_ba_zero, e_hazard, e_sel_err;
  logic [15:0] exp_q[$];

  reg_select_unit dut (
    .clock(clock), .reset_n(reset_n), .ir_in(ir_in), .ir_load(ir_load),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .c_zext(c_zext), .reserve(reserve), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .ir_q(ir_q), .r_en(r_en), .r_out(r_out), .c_ext(c_ext), .sel_idx(sel_idx),
    .ba_zero(ba_zero), .hazard(hazard), .sel_err(sel_err), .busy(busy)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Model: fields by shift/mask, priority by plain if-chain.
  function automatic void model_eval();
    int ra, rb, rc, idx, nsel;
    logic any;
    logic [31:0] cval;
    ra   = int'((ir_m >> 23) & 32'hF);
    rb   = int'((ir_m >> 19) & 32'hF);
    rc   = int'((ir_m >> 15) & 32'hF);
    any  = gra | grb | grc;
    nsel = int'(gra) + int'(grb) + int'(grc);
    if (gra)      idx = ra;
    else if (grb) idx = rb;
    else if (grc) idx = rc;
    else          idx = 0;
    e_sel_idx = idx;
    e_sel_err = (nsel >= 2);
    e_ba_zero = baout && any && (idx == 0);
    e_r_en    = (rin && any) ? 16'(1 << idx) : 16'h0;
    e_r_out   = ((rout || baout) && any && !e_ba_zero) ? 16'(1 << idx) : 16'h0;
    e_hazard  = (rout || baout) && any && busy_m[idx] && !e_ba_zero;
    cval      = ir_m & 32'h7FFFF;
    if (!c_zext && cval >= 32'h40000) e_c_ext = cval - 32'h80000;
    else                              e_c_ext = cval;
    ir_n   = ir_load ? ir_in : ir_m;
    busy_n = busy_m;
    if (wb_valid) busy_n[wb_idx] = 1'b0;
    if (reserve && any) busy_n[idx] = 1'b1;
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    ir_in = '0; ir_load = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0;
    baout = 0; c_zext = 0; reserve = 0; wb_valid = 0; wb_idx = '0;
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clock);
    ir_m   = ir_n;
    busy_m = busy_n;
    @(negedge clock);
  endtask

  task automatic load_ir(input logic [31:0] v);
    clear_inputs();
    ir_in = v; ir_load = 1;
    cycle();
    ir_load = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    ir_m = '0; busy_m = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (ir_q !== 32'h0) begin errors++; $display("FAIL reset_ir_q: got %h expected 0", ir_q); end
    checks++;
    if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy); end
    checks++;
    if ({r_en, r_out, c_ext, sel_idx, ba_zero, hazard, sel_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got r_en=%h r_out=%h c_ext=%h sel=%0d flags=%b%b%b expected all 0",
               r_en, r_out, c_ext, sel_idx, ba_zero, hazard, sel_err);
    end
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
  endtask

  task automatic test_decode();
    load_ir(32'h0A9B_8000);
    gra = 1; rin = 1; #1;
    checks++;
    if (r_en !== 16'h0020 || r_out !== 16'h0) begin
      errors++; $display("FAIL decode_ra_rin: got r_en=%h r_out=%h expected 0020/0000", r_en, r_out);
    end
    clear_inputs(); grb = 1; rout = 1; #1;
    checks++;
    if (r_out !== 16'h0008 || r_en !== 16'h0 || sel_idx !== 4'd3) begin
      errors++; $display("FAIL decode_rb_rout: got r_out=%h r_en=%h sel=%0d expected 0008/0000/3", r_out, r_en, sel_idx);
    end
    clear_inputs(); grc = 1; rin = 1; #1;
    checks++;
    if (r_en !== 16'h0080 || sel_idx !== 4'd7) begin
      errors++; $display("FAIL decode_rc_rin: got r_en=%h sel=%0d expected 0080/7", r_en, sel_idx);
    end
    clear_inputs(); rin = 1; rout = 1; #1;
    checks++;
    if (r_en !== 16'h0 || r_out !== 16'h0 || sel_idx !== 4'd0) begin
      errors++; $display("FAIL decode_no_sel: got r_en=%h r_out=%h sel=%0d expected 0/0/0", r_en, r_out, sel_idx);
    end
    clear_inputs(); gra = 1; grc = 1; rout = 1; #1;
    checks++;
    if (sel_err !== 1'b1 || sel_idx !== 4'd5 || r_out !== 16'h0020) begin
      errors++; $display("FAIL sel_err_priority: got err=%b sel=%0d r_out=%h expected 1/5/0020", sel_err, sel_idx, r_out);
    end
    clear_inputs(); grb = 1; grc = 1; #1;
    checks++;
    if (sel_err !== 1'b1 || sel_idx !== 4'd3) begin
      errors++; $display("FAIL sel_err_rb_rc: got err=%b sel=%0d expected 1/3", sel_err, sel_idx);
    end
    clear_inputs();
  endtask

  task automatic test_const();
    load_ir(32'h0004_0000);
    c_zext = 0; #1;
    checks++;
    if (c_ext !== 32'hFFFC_0000) begin errors++; $display("FAIL c_sext: got %h expected fffc0000", c_ext); end
    c_zext = 1; #1;
    checks++;
    if (c_ext !== 32'h0004_0000) begin errors++; $display("FAIL c_zext: got %h expected 00040000", c_ext); end
    load_ir(32'hFFF3_FFFF);
    c_zext = 0; #1;
    checks++;
    if (c_ext !== 32'h0003_FFFF) begin errors++; $display("FAIL c_sext_pos: got %h expected 0003ffff", c_ext); end
    clear_inputs();
  endtask

  task automatic test_base_zero();
    load_ir(32'h0280_0000);  // Ra=5, Rb=0
    grb = 1; reserve = 1;
    cycle();
    clear_inputs();
    checks++;
    if (busy !== 16'h0001) begin errors++; $display("FAIL reserve_r0: got %h expected 0001", busy); end
    grb = 1; baout = 1; #1;
    checks++;
    if (r_out !== 16'h0 || ba_zero !== 1'b1 || hazard !== 1'b0) begin
      errors++; $display("FAIL base_zero: got r_out=%h ba_zero=%b hazard=%b expected 0/1/0", r_out, ba_zero, hazard);
    end
    baout = 0; rout = 1; #1;
    checks++;
    if (r_out !== 16'h0001 || hazard !== 1'b1 || ba_zero !== 1'b0) begin
      errors++; $display("FAIL r0_rout_hazard: got r_out=%h hazard=%b ba_zero=%b expected 0001/1/0", r_out, hazard, ba_zero);
    end
    clear_inputs(); wb_valid = 1; wb_idx = 4'd0;
    cycle();
    clear_inputs();
  endtask

  task automatic test_hazard();
    load_ir(32'h0280_0000);  // Ra=5
    gra = 1; reserve = 1;
    cycle();
    clear_inputs();
    checks++;
    if (busy !== 16'h0020) begin errors++; $display("FAIL reserve_r5: got %h expected 0020", busy); end
    load_ir(32'h0028_0000);  // Rb=5
    grb = 1; rout = 1; #1;
    checks++;
    if (hazard !== 1'b1 || r_out !== 16'h0020) begin
      errors++; $display("FAIL raw_hazard: got hazard=%b r_out=%h expected 1/0020", hazard, r_out);
    end
    wb_valid = 1; wb_idx = 4'd5;
    cycle();
    wb_valid = 0; #1;
    checks++;
    if (busy !== 16'h0 || hazard !== 1'b0) begin
      errors++; $display("FAIL writeback_clear: got busy=%h hazard=%b expected 0000/0", busy, hazard);
    end
    clear_inputs(); wb_valid = 1; wb_idx = 4'd9;
    cycle();
    clear_inputs();
    checks++;
    if (busy !== 16'h0) begin errors++; $display("FAIL wb_idle: got %h expected 0000", busy); end
    reserve = 1;
    cycle();
    clear_inputs();
    checks++;
    if (busy !== 16'h0) begin errors++; $display("FAIL reserve_no_sel: got %h expected 0000", busy); end
  endtask

  task automatic test_set_wins();
    load_ir(32'h0280_0000);  // Ra=5
    gra = 1; reserve = 1; wb_valid = 1; wb_idx = 4'd5;
    cycle();
    clear_inputs();
    checks++;
    if (busy !== 16'h0020) begin errors++; $display("FAIL set_wins: got %h expected 0020", busy); end
    wb_valid = 1; wb_idx = 4'd5;
    cycle();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) begin
      load_ir(32'(i) << 23);
      gra = 1; reserve = 1;
      cycle();
      clear_inputs();
    end
    checks++;
    if (busy !== 16'hFFFF) begin errors++; $display("FAIL reserve_all: got %h expected ffff", busy); end
    #1 reset_n = 0;
    #2;
    checks++;
    if (busy !== 16'h0 || ir_q !== 32'h0) begin
      errors++; $display("FAIL async_reset: got busy=%h ir_q=%h expected 0/0", busy, ir_q);
    end
    #1 reset_n = 1;
    ir_m = '0; busy_m = '0;
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [15:0] exp_b;
    for (int n = 0; n < 400; n++) begin
      ir_in    = $urandom;
      ir_load  = ($urandom_range(0, 3) == 0);
      gra      = $urandom_range(0, 1); grb = $urandom_range(0, 1); grc = $urandom_range(0, 1);
      rin      = $urandom_range(0, 1); rout = $urandom_range(0, 1); baout = ($urandom_range(0, 3) == 0);
      c_zext   = $urandom_range(0, 1);
      reserve  = ($urandom_range(0, 2) == 0);
      wb_valid = $urandom_range(0, 1);
      wb_idx   = 4'($urandom_range(0, 15));
      #1;
      model_eval();
      checks++;
      if (r_en !== e_r_en || r_out !== e_r_out || sel_idx !== 4'(e_sel_idx) || c_ext !== e_c_ext ||
          ba_zero !== e_ba_zero || hazard !== e_hazard || sel_err !== e_sel_err) begin
        errors++;
        $display("FAIL random_comb[%0d]: got r_en=%h r_out=%h sel=%0d c=%h bz=%b hz=%b se=%b expected %h %h %0d %h %b %b %b",
                 n, r_en, r_out, sel_idx, c_ext, ba_zero, hazard, sel_err,
                 e_r_en, e_r_out, e_sel_idx, e_c_ext, e_ba_zero, e_hazard, e_sel_err);
      end
      exp_q.push_back(busy_n);
      cycle();
      exp_b = exp_q.pop_front();
      checks++;
      if (busy !== exp_b || ir_q !== ir_m) begin
        errors++; $display("FAIL random_state[%0d]: got busy=%h ir_q=%h expected %h %h", n, busy, ir_q, exp_b, ir_m);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    test_reset();
    test_decode();
    test_const();
    test_base_zero();
    test_hazard();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
